aes_core_sequencer: RTL and testbench

//  Top-level sequencer for the AES core. Accepts init/next commands from the register front-end.

---
 rtl/aes_core_sequencer_pkg.sv | 25 ++
 rtl/aes_core_sequencer_watchdog.sv | 38 +++
 rtl/aes_core_sequencer.sv | 175 +++++++++++++++++
 tb/tb_aes_core_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_core_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_core_sequencer_pkg
//  Description : Shared types and constants for the AES core sequencer:
//                sequencer state encoding, key-length codes, round counts.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_core_sequencer_pkg;

    // Sequencer states, explicitly encoded
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KINIT  = 3'd1,
        KWAIT  = 3'd2,
        BSTART = 3'd3,
        BWAIT  = 3'd4
    } aes_seq_state_e;

    localparam logic AES_128_BIT_KEY    = 1'b0;
    localparam logic AES_256_BIT_KEY    = 1'b1;
    localparam int   AES_128_NUM_ROUNDS = 10;
    localparam int   AES_256_NUM_ROUNDS = 14;

endpackage : aes_core_sequencer_pkg
`default_nettype wire

// File: rtl/aes_core_sequencer_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : aes_core_sequencer_watchdog
//  Description : Per-step watchdog. Cleared on entry to a wait state, counts
//                once per cycle while enabled, flags expiry on the last
//                allowed cycle and flags the first (guard) cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_core_sequencer_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired,
    output logic o_first
);

    localparam int                 c_cnt_w = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0] r_count;

    // Count wait cycles; saturate at the last value so expiry stays asserted
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_last)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == c_last);
    assign o_first   = (r_count == '0);

endmodule : aes_core_sequencer_watchdog
`default_nettype wire

// File: rtl/aes_core_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : aes_core_sequencer
//  Description : Top-level AES core sequencer. Accepts init/next commands,
//                drives key expansion and the encipher/decipher blocks,
//                arbitrates the shared S-box and aborts stuck steps.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_core_sequencer
    import aes_core_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        init_i,
    input  logic        next_i,
    input  logic        encdec_i,
    input  logic        keylen_i,
    output logic        ready_o,
    output logic        key_ready_o,
    output logic        result_valid_o,
    output logic        err_o,
    output logic        kx_init_o,
    output logic        kx_keylen_o,
    input  logic        kx_ready_i,
    output logic [3:0]  kx_round_o,
    input  logic [31:0] kx_sboxw_i,
    output logic        enc_next_o,
    input  logic        enc_ready_i,
    input  logic [3:0]  enc_round_i,
    input  logic [31:0] enc_sboxw_i,
    output logic        dec_next_o,
    input  logic        dec_ready_i,
    input  logic [3:0]  dec_round_i,
    output logic [31:0] sboxw_o
);

    aes_seq_state_e r_state;
    logic           r_key_ready;
    logic           r_result_valid;
    logic           r_err;
    logic           r_kx_init;
    logic           r_kx_keylen;
    logic           r_enc_next;
    logic           r_dec_next;
    logic           r_encdec;

    logic w_rst;
    logic w_wd_clear;
    logic w_wd_enable;
    logic w_wd_expired;
    logic w_wd_first;
    logic w_blk_ready;
    logic w_cmd;

    assign w_rst       = ~reset_n;
    // Clearing in the one-cycle launch states guarantees a zero count on wait entry
    assign w_wd_clear  = (r_state == KINIT) || (r_state == BSTART);
    assign w_wd_enable = (r_state == KWAIT) || (r_state == BWAIT);
    assign w_blk_ready = r_encdec ? enc_ready_i : dec_ready_i;
    assign w_cmd       = init_i | next_i;

    aes_core_sequencer_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (w_rst),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_enable),
        .o_expired (w_wd_expired),
        .o_first   (w_wd_first)
    );

    // Sequencer FSM with registered command/status outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_key_ready    <= 1'b0;
            r_result_valid <= 1'b0;
            r_err          <= 1'b0;
            r_kx_init      <= 1'b0;
            r_kx_keylen    <= AES_128_BIT_KEY;
            r_enc_next     <= 1'b0;
            r_dec_next     <= 1'b0;
            r_encdec       <= 1'b1;
        end else begin
            r_err      <= 1'b0;
            r_kx_init  <= 1'b0;
            r_enc_next <= 1'b0;
            r_dec_next <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (init_i) begin
                        // init wins over a simultaneous next, which is reported
                        r_state        <= KINIT;
                        r_kx_keylen    <= keylen_i;
                        r_key_ready    <= 1'b0;
                        r_result_valid <= 1'b0;
                        r_kx_init      <= 1'b1;
                        r_err          <= next_i;
                    end else if (next_i) begin
                        if (r_key_ready) begin
                            r_state        <= BSTART;
                            r_encdec       <= encdec_i;
                            r_result_valid <= 1'b0;
                            r_enc_next     <= encdec_i;
                            r_dec_next     <= ~encdec_i;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                KINIT: begin
                    r_state <= KWAIT;
                    r_err   <= w_cmd;
                end
                BSTART: begin
                    r_state <= BWAIT;
                    r_err   <= w_cmd;
                end
                KWAIT: begin
                    // Sub-block ready is stale during the first wait cycle
                    if (!w_wd_first && kx_ready_i) begin
                        r_state     <= IDLE;
                        r_key_ready <= 1'b1;
                        r_err       <= w_cmd;
                    end else if (w_wd_expired) begin
                        r_state     <= IDLE;
                        r_key_ready <= 1'b0;
                        r_err       <= 1'b1;
                    end else begin
                        r_err <= w_cmd;
                    end
                end
                BWAIT: begin
                    if (!w_wd_first && w_blk_ready) begin
                        r_state        <= IDLE;
                        r_result_valid <= 1'b1;
                        r_err          <= w_cmd;
                    end else if (w_wd_expired) begin
                        r_state        <= IDLE;
                        r_result_valid <= 1'b0;
                        r_err          <= 1'b1;
                    end else begin
                        r_err <= w_cmd;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Shared S-box: key expansion owns it only during the key phase
    always_comb begin
        sboxw_o = enc_sboxw_i;
        if ((r_state == KINIT) || (r_state == KWAIT)) begin
            sboxw_o = kx_sboxw_i;
        end
    end

    assign kx_round_o     = r_encdec ? enc_round_i : dec_round_i;
    assign ready_o        = (r_state == IDLE);
    assign key_ready_o    = r_key_ready;
    assign result_valid_o = r_result_valid;
    assign err_o          = r_err;
    assign kx_init_o      = r_kx_init;
    assign kx_keylen_o    = r_kx_keylen;
    assign enc_next_o     = r_enc_next;
    assign dec_next_o     = r_dec_next;

endmodule : aes_core_sequencer
`default_nettype wire

// File: tb/tb_aes_core_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_core_sequencer
//  Description : Scoreboard bench for aes_core_sequencer. Stub sub-blocks
//                answer after a chosen latency (0 = never); a transaction
//                model predicts each operation's outcome and busy length.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_core_sequencer;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        init_i = 1'b0, next_i = 1'b0, encdec_i = 1'b0, keylen_i = 1'b0;
    logic        ready_o, key_ready_o, result_valid_o, err_o;
    logic        kx_init_o, kx_keylen_o, enc_next_o, dec_next_o;
    logic        kx_ready_i = 1'b1, enc_ready_i = 1'b1, dec_ready_i = 1'b1;
    logic [3:0]  kx_round_o, enc_round_i = 4'd0, dec_round_i = 4'd0;
    logic [31:0] kx_sboxw_i = '0, enc_sboxw_i = '0, sboxw_o;

    always #5 clk = ~clk;

    aes_core_sequencer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .init_i(init_i), .next_i(next_i),
        .encdec_i(encdec_i), .keylen_i(keylen_i), .ready_o(ready_o),
        .key_ready_o(key_ready_o), .result_valid_o(result_valid_o), .err_o(err_o),
        .kx_init_o(kx_init_o), .kx_keylen_o(kx_keylen_o), .kx_ready_i(kx_ready_i),
        .kx_round_o(kx_round_o), .kx_sboxw_i(kx_sboxw_i), .enc_next_o(enc_next_o),
        .enc_ready_i(enc_ready_i), .enc_round_i(enc_round_i), .enc_sboxw_i(enc_sboxw_i),
        .dec_next_o(dec_next_o), .dec_ready_i(dec_ready_i), .dec_round_i(dec_round_i),
        .sboxw_o(sboxw_o)
    );

    // Stub sub-blocks: ready stays stale one cycle after the start pulse,
    // then drops and rises again after the programmed latency (0 = stuck).
    int kx_lat = 1, blk_lat = 1;
    int kx_cnt = 0, enc_cnt = 0, dec_cnt = 0;
    logic kx_d = 1'b0, enc_d = 1'b0, dec_d = 1'b0;

    always @(posedge clk) begin
        kx_d <= kx_init_o; enc_d <= enc_next_o; dec_d <= dec_next_o;
        if (kx_d) begin kx_ready_i <= 1'b0; kx_cnt <= kx_lat; end
        else if (kx_cnt > 0) begin kx_cnt <= kx_cnt - 1; if (kx_cnt == 1) kx_ready_i <= 1'b1; end
        if (enc_d) begin enc_ready_i <= 1'b0; enc_cnt <= blk_lat; end
        else if (enc_cnt > 0) begin enc_cnt <= enc_cnt - 1; if (enc_cnt == 1) enc_ready_i <= 1'b1; end
        if (dec_d) begin dec_ready_i <= 1'b0; dec_cnt <= blk_lat; end
        else if (dec_cnt > 0) begin dec_cnt <= dec_cnt - 1; if (dec_cnt == 1) dec_ready_i <= 1'b1; end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit idle_err;
        int low, err, enc, dec, kxi;
        bit key_ready, result_valid, keylen;
    } exp_t;
    exp_t q[$];

    // Reference state of the sequencer at transaction level
    bit m_key_valid = 0, m_result = 0, m_encdec = 1, m_keylen = 0;
    bit mon_en = 0;

    // Monitor: accumulate activity while busy, compare on each completion or idle rejection
    initial begin
        int a_low, a_err, a_enc, a_dec, a_kxi;
        bit prev;
        exp_t e;
        a_low = 0; a_err = 0; a_enc = 0; a_dec = 0; a_kxi = 0; prev = 1;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                a_low = 0; a_err = 0; a_enc = 0; a_dec = 0; a_kxi = 0; prev = ready_o;
            end else begin
                a_err += int'(err_o); a_enc += int'(enc_next_o);
                a_dec += int'(dec_next_o); a_kxi += int'(kx_init_o);
                if (!ready_o) a_low++;
                if (ready_o && (!prev || err_o)) begin
                    if (q.size() == 0) begin
                        chk("unexpected_event", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("event_kind", {31'd0, prev}, {31'd0, e.idle_err});
                        chk("busy_cycles", a_low, e.low);
                        chk("err_pulses", a_err, e.err);
                        chk("enc_next_pulses", a_enc, e.enc);
                        chk("dec_next_pulses", a_dec, e.dec);
                        chk("kx_init_pulses", a_kxi, e.kxi);
                        chk("key_ready_o", key_ready_o, e.key_ready);
                        chk("result_valid_o", result_valid_o, e.result_valid);
                        chk("kx_keylen_o", kx_keylen_o, e.keylen);
                    end
                    a_low = 0; a_err = 0; a_enc = 0; a_dec = 0; a_kxi = 0;
                end
                prev = ready_o;
            end
        end
    end

    task automatic randomize_sbox();
        kx_sboxw_i  = $urandom; enc_sboxw_i = $urandom;
        enc_round_i = 4'($urandom); dec_round_i = 4'($urandom);
    endtask

    // Issue one command, predict its outcome and push it to the scoreboard
    task automatic do_op(input bit is_init, input bit val, input int lat,
                         input bit simul, input bit midwait, input bit mid_is_init);
        exp_t e;
        bit   done;
        e = '{idle_err: 0, low: 0, err: 0, enc: 0, dec: 0, kxi: 0,
              key_ready: 0, result_valid: 0, keylen: 0};
        if (!is_init && !m_key_valid) begin
            e.idle_err = 1; e.err = 1;
            e.key_ready = 0; e.result_valid = m_result; e.keylen = m_keylen;
            q.push_back(e);
            @(negedge clk); next_i = 1; encdec_i = val;
            @(negedge clk); next_i = 0; encdec_i = $urandom;
            repeat (2) @(negedge clk);
            return;
        end
        // The step completes only if ready shows up by the last watchdog cycle
        done  = (lat != 0) && (lat + 1 <= TIMEOUT - 1);
        e.low = done ? lat + 3 : TIMEOUT + 1;
        if (is_init) begin
            kx_lat = lat;
            m_keylen = val; m_key_valid = done; m_result = 0;
            e.kxi = 1; e.err = int'(simul) + int'(midwait) + int'(!done);
        end else begin
            blk_lat = lat;
            m_encdec = val; m_result = done;
            e.enc = int'(val); e.dec = int'(!val);
            e.err = int'(midwait) + int'(!done);
        end
        e.key_ready = m_key_valid; e.result_valid = m_result; e.keylen = m_keylen;
        q.push_back(e);

        @(negedge clk);
        init_i = is_init; next_i = !is_init || simul; keylen_i = val; encdec_i = val;
        @(negedge clk);
        init_i = 0; next_i = 0; keylen_i = $urandom; encdec_i = $urandom;
        @(negedge clk);
        // Inside the wait state: S-box owner and round-key source
        randomize_sbox();
        if (midwait) begin
            init_i = mid_is_init; next_i = !mid_is_init; keylen_i = !val; encdec_i = !val;
        end
        #1;
        chk("sboxw_o_busy", sboxw_o, is_init ? kx_sboxw_i : enc_sboxw_i);
        chk("kx_round_o_busy", {28'd0, kx_round_o}, {28'd0, m_encdec ? enc_round_i : dec_round_i});
        @(negedge clk);
        init_i = 0; next_i = 0;
        for (int i = 0; i < 200 && !ready_o; i++) @(negedge clk);
        if (!ready_o) chk("op_completion_timeout", 0, 1);
        @(negedge clk);
        randomize_sbox();
        #1;
        chk("sboxw_o_idle", sboxw_o, enc_sboxw_i);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready_o"}, ready_o, 1);
        chk({tag, "_key_ready_o"}, key_ready_o, 0);
        chk({tag, "_result_valid_o"}, result_valid_o, 0);
        chk({tag, "_err_o"}, err_o, 0);
        chk({tag, "_kx_init_o"}, kx_init_o, 0);
        chk({tag, "_kx_keylen_o"}, kx_keylen_o, 0);
        chk({tag, "_enc_next_o"}, enc_next_o, 0);
        chk({tag, "_dec_next_o"}, dec_next_o, 0);
        chk({tag, "_kx_round_o"}, {28'd0, kx_round_o}, {28'd0, enc_round_i});
    endtask

    initial begin
        randomize_sbox();
        reset_n = 0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset_n = 1;
        @(negedge clk);
        mon_en = 1;

        // Directed: reject without key, both key sizes, both directions, aborts, boundaries
        do_op(0, 1, 5, 0, 0, 0);     // next with no key schedule
        do_op(1, 0, 5, 0, 0, 0);     // AES-128 expansion
        do_op(0, 1, 12, 0, 0, 0);    // encrypt, 12-cycle stub
        do_op(0, 0, 7, 0, 1, 1);     // decrypt with stray init mid-wait
        do_op(1, 1, 0, 0, 0, 0);     // AES-256 expansion never completes
        do_op(0, 1, 3, 0, 0, 0);     // rejected: key cleared by abort
        do_op(1, 1, 62, 1, 0, 0);    // init+next together, ready on last cycle
        do_op(0, 1, 63, 0, 1, 0);    // block abort one cycle too late, key kept
        do_op(0, 0, 1, 0, 0, 0);     // shortest decrypt

        // Randomised operations
        for (int n = 0; n < 40; n++) begin
            int lat, r;
            r = $urandom_range(0, 9);
            lat = (r == 0) ? 0 : (r == 1) ? $urandom_range(60, 64) : $urandom_range(1, 20);
            do_op($urandom_range(0, 2) == 0, 1'($urandom), lat,
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0), 1'($urandom));
        end

        // Reset in the middle of a block operation
        if (!m_key_valid) do_op(1, 0, 4, 0, 0, 0);
        mon_en = 0;
        blk_lat = 40;
        @(negedge clk); next_i = 1; encdec_i = 0;
        @(negedge clk); next_i = 0;
        repeat (4) @(negedge clk);
        chk("bwait_busy_before_reset", ready_o, 0);
        reset_n = 0;
        @(negedge clk);
        check_reset_values("midop_reset");
        reset_n = 1;
        m_key_valid = 0; m_result = 0; m_encdec = 1; m_keylen = 0;
        repeat (2) @(negedge clk);
        mon_en = 1;
        do_op(0, 1, 4, 0, 0, 0);     // key gone after reset
        do_op(1, 1, 9, 0, 0, 0);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_aes_core_sequencer
`default_nettype wire
